// File: rtl/wu_fetch.sv
// wu_fetch: WU instruction fetch stage, sequential reads with decode stall,
// end-of-WU drain/flush and a per-WU issued-instruction counter.
module wu_fetch #(
    parameter int AW      = 10,
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset_poweron_n,
    input  logic             mcntl__wuf__start,
    input  logic [AW-1:0]    mcntl__wuf__start_addr,
    output logic             wuf__mcntl__ready,
    output logic [AW-1:0]    wuf__wum__addr,
    output logic             wuf__wum__read,
    input  logic             wud__wuf__stall,
    input  logic             wud__wuf__done,
    output logic             wuf__wud__flush,
    output logic             wuf__mcntl__complete,
    output logic [CNT_W-1:0] wuf__stat__count
);
    localparam int DW = $clog2(MEM_LAT + 2);
    typedef enum logic [1:0] {IDLE, FETCH, STALL, DRAIN} state_t;
    state_t state, state_nx;
    logic [AW-1:0] pc, pc_nx, addr_nx, issue_pc;
    logic [CNT_W-1:0] count_nx, base_count;
    logic [DW-1:0] dcnt, dcnt_nx;
    logic busy, issue, read_nx, flush_nx, complete_nx;

    // A start in IDLE issues its first read on the same edge, so the read shows the cycle after start.
    always_comb begin
        busy        = state == FETCH || state == STALL;
        issue       = (state == IDLE && mcntl__wuf__start) || (busy && !wud__wuf__done && !wud__wuf__stall);
        issue_pc    = state == IDLE ? mcntl__wuf__start_addr : pc;
        base_count  = state == IDLE ? '0 : wuf__stat__count;
        state_nx    = state;
        pc_nx       = pc;
        addr_nx     = wuf__wum__addr;
        count_nx    = wuf__stat__count;
        dcnt_nx     = dcnt;
        read_nx     = 1'b0;
        flush_nx    = 1'b0;
        complete_nx = 1'b0;
        if (issue) begin
            state_nx = FETCH;
            read_nx  = 1'b1;
            addr_nx  = issue_pc;
            pc_nx    = issue_pc + AW'(1);
            count_nx = &base_count ? base_count : base_count + CNT_W'(1);
        end else if (busy && wud__wuf__done) begin
            state_nx = DRAIN;
            flush_nx = 1'b1;
            dcnt_nx  = DW'(MEM_LAT + 1);
        end else if (busy) begin
            state_nx = STALL;
        end else if (state == DRAIN) begin
            dcnt_nx     = dcnt - DW'(1);
            flush_nx    = dcnt != DW'(1);
            complete_nx = dcnt == DW'(2);
            state_nx    = dcnt == DW'(1) ? IDLE : DRAIN;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_poweron_n) begin
            state                <= IDLE;
            pc                   <= '0;
            dcnt                 <= '0;
            wuf__mcntl__ready    <= 1'b1;
            wuf__wum__read       <= 1'b0;
            wuf__wum__addr       <= '0;
            wuf__wud__flush      <= 1'b0;
            wuf__mcntl__complete <= 1'b0;
            wuf__stat__count     <= '0;
        end else begin
            state                <= state_nx;
            pc                   <= pc_nx;
            dcnt                 <= dcnt_nx;
            wuf__mcntl__ready    <= state_nx == IDLE;
            wuf__wum__read       <= read_nx;
            wuf__wum__addr       <= addr_nx;
            wuf__wud__flush      <= flush_nx;
            wuf__mcntl__complete <= complete_nx;
            wuf__stat__count     <= count_nx;
        end
    end
endmodule

// File: doc/wu_fetch.md
Name: wu_fetch

Overview:
- Work-unit (WU) instruction fetch stage for the manager.
- Accepts a start address from the manager control path, then issues sequential read requests (address plus read strobe) to the WU instruction memory.
- The memory returns each instruction to WU decode 2 cycles after the request.
- Fetch honours a decode stall, stops when decode reports end-of-WU, and flushes in-flight reads before returning to idle.

Parameters:
AW, 10, WU instruction memory address width (depth 2^AW)
MEM_LAT, 2, cycles from a read request to the memory's valid output at decode
CNT_W, 16, width of the per-WU fetched-instruction counter

Ports:
clk  in  1  clock; all logic on rising edge
reset_poweron_n  in  1  reset, synchronous, active-low
mcntl__wuf__start  in  1  start request; qualified by wuf__mcntl__ready
mcntl__wuf__start_addr  in  AW  first instruction address of the WU
wuf__mcntl__ready  out  1  fetch idle, start accepted this cycle
wuf__wum__addr  out  AW  read address to WU memory
wuf__wum__read  out  1  read strobe; one instruction per cycle asserted
wud__wuf__stall  in  1  decode cannot accept further instructions
wud__wuf__done  in  1  decode consumed the final instruction of the WU (single-cycle pulse)
wuf__wud__flush  out  1  decode must discard memory-valid data this cycle
wuf__mcntl__complete  out  1  single-cycle pulse, WU fetch finished and drained
wuf__stat__count  out  CNT_W  instructions issued for the current or last WU

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-low (reset_poweron_n).
- Reset values:
  - state = IDLE, wuf__mcntl__ready = 1
  - wuf__wum__read = 0, wuf__wum__addr = 0
  - wuf__wud__flush = 0, wuf__mcntl__complete = 0, wuf__stat__count = 0
  - drain counter = 0
- All outputs are registered.
- States: IDLE, FETCH, STALL, DRAIN.
- IDLE:
  - ready = 1, read = 0.
  - On start = 1: load pc = start_addr, clear count, go to FETCH.
  - The first read (addr = start_addr) appears on the cycle after start.
  - Start is ignored in any other state; ready is 0 outside IDLE.
- FETCH:
  - Each cycle: read = 1, addr = pc; then pc = pc + 1, count = count + 1.
  - pc wraps from 2^AW-1 to 0.
  - count saturates at 2^CNT_W-1.
- Stall:
  - stall = 1 in FETCH: read deasserts next cycle, go to STALL; pc holds the next unissued address.
  - Decode must absorb up to MEM_LAT+1 (= 3) instructions already requested; no address rewind.
  - STALL: read = 0. When stall = 0, return to FETCH; the next issued addr is the held pc, with no gap or duplicate.
- Done:
  - done = 1 in FETCH or STALL: read = 0 next cycle, go to DRAIN, load drain counter = MEM_LAT+1.
  - Done takes priority over a simultaneous stall.
- DRAIN:
  - flush = 1 every cycle in DRAIN, so decode drops reads issued past the end of the WU.
  - Decrement the drain counter. At 1, pulse complete = 1, go to IDLE; ready = 1 the following cycle.
  - done or stall arriving in DRAIN is ignored.
- done in IDLE is ignored: no complete pulse, no state change.
- Reset asserted mid-FETCH/STALL/DRAIN forces IDLE next edge:
  - In-flight reads are abandoned.
  - No complete pulse.
  - flush = 0.
- count retains its final value in IDLE until the next accepted start.

Test Plan:
1. Basic run. Reset, start with start_addr = 0x010; done pulsed 6 cycles after the first read.
   - Required: addr 0x010..0x015 on consecutive cycles, each with read = 1.
   - flush high 3 cycles, complete pulses once, count = 6, ready = 1 afterwards.
2. Stall mid-run. Stall held 4 cycles after addr 0x012 is issued.
   - Required: read = 0 for those cycles; next read addr = 0x013.
   - No repeated or skipped address; count excludes stalled cycles.
3. Wrap-around. start_addr = 0x3FE with AW = 10.
   - Required: addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
4. Simultaneous stall and done in FETCH.
   - Required: DRAIN entered; complete after 3 cycles; later stall transitions ignored.
5. Start while busy and done while idle.
   - Second start during FETCH (start_addr = 0x100) is ignored: addr continues sequentially, ready = 0.
   - done pulse in IDLE produces no complete.
6. Reset mid-DRAIN: reset_poweron_n = 0 on the second flush cycle.
   - Required: next cycle all outputs at reset values, no complete pulse.
   - A new start then fetches normally from its start_addr.
